// File: rtl/mc_ctrl_unit_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// datapath select codes, FSM states and the decoded control word.
package mc_ctrl_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] DTR_ALU = 2'b00;
  localparam logic [1:0] DTR_MEM = 2'b01;
  localparam logic [1:0] DTR_LUI = 2'b10;
  localparam logic [1:0] DTR_PC4 = 2'b11;

  localparam logic [1:0] BR_PC4    = 2'b00;
  localparam logic [1:0] BR_TARGET = 2'b01;
  localparam logic [1:0] BR_JUMP   = 2'b10;
  localparam logic [1:0] BR_JR     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_COMMIT, S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    BRC_NONE, BRC_BEQ, BRC_BNE, BRC_J, BRC_JR
  } brc_e;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       jal;
    logic       regwrite;
    logic [1:0] dtr;
    brc_e       brc;
    logic [2:0] alu;
    logic       is_mem;
    logic       is_store;
  } ctrl_t;

  // Conditional branches only resolve once the sampled zero flag is known.
  function automatic logic [1:0] br_resolve(brc_e c, logic z);
    case (c)
      BRC_BEQ: return z ? BR_TARGET : BR_PC4;
      BRC_BNE: return z ? BR_PC4 : BR_TARGET;
      BRC_J:   return BR_JUMP;
      BRC_JR:  return BR_JR;
      default: return BR_PC4;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct -> datapath control word.
module mc_ctrl_decode
  import mc_ctrl_unit_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.dtr      = DTR_ALU;
        case (funct_i)
          FN_ADD: ctrl_o.alu = ALU_ADD;
          FN_SUB: ctrl_o.alu = ALU_SUB;
          FN_AND: ctrl_o.alu = ALU_AND;
          FN_OR:  ctrl_o.alu = ALU_OR;
          FN_XOR: ctrl_o.alu = ALU_XOR;
          FN_NOR: ctrl_o.alu = ALU_NOR;
          FN_SLT: ctrl_o.alu = ALU_SLT;
          FN_SRL: ctrl_o.alu = ALU_SRL;
          FN_JR: begin
            ctrl_o.regdst   = 1'b0;
            ctrl_o.regwrite = 1'b0;
            ctrl_o.brc      = BRC_JR;
          end
          default: begin
            ctrl_o    = '0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        case (opcode_i)
          OP_ANDI: ctrl_o.alu = ALU_AND;
          OP_ORI:  ctrl_o.alu = ALU_OR;
          OP_XORI: ctrl_o.alu = ALU_XOR;
          OP_SLTI: ctrl_o.alu = ALU_SLT;
          default: ctrl_o.alu = ALU_ADD;
        endcase
      end
      OP_LUI: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.dtr      = DTR_LUI;
      end
      OP_LW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.dtr      = DTR_MEM;
        ctrl_o.alu      = ALU_ADD;
        ctrl_o.is_mem   = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.alu      = ALU_ADD;
        ctrl_o.is_mem   = 1'b1;
        ctrl_o.is_store = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu = ALU_SUB;
        ctrl_o.brc = BRC_BEQ;
      end
      OP_BNE: begin
        ctrl_o.alu = ALU_SUB;
        ctrl_o.brc = BRC_BNE;
      end
      OP_J: ctrl_o.brc = BRC_J;
      OP_JAL: begin
        ctrl_o.brc      = BRC_J;
        ctrl_o.jal      = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.dtr      = DTR_PC4;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle sequencer: fetch over req/ack, decode into a held control word,
// optional data-memory access, then a single commit strobe per instruction.
module mc_ctrl_unit
  import mc_ctrl_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      inst,
  output logic             inst_req,
  input  logic             inst_ack,
  output logic             mem_req,
  output logic             mem_wr,
  input  logic             mem_ack,
  input  logic             zero,
  output logic [25:0]      inst_field,
  output logic             RegDst,
  output logic             ALUSrc_B,
  output logic             Jal,
  output logic             RegWrite,
  output logic [1:0]       DatatoReg,
  output logic [1:0]       Branch,
  output logic [2:0]       ALU_Control,
  output logic             cpu_en,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0]       TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RET_ONE  = 1;

  state_e           state_q, state_d;
  logic [25:0]      ir_q;
  ctrl_t            ctrl_q, dec_ctrl;
  logic             dec_illegal;
  logic [7:0]       cnt_q;
  logic             z_q;
  logic             inst_req_q, mem_req_q, mem_wr_q, cpu_en_q, regwrite_q;
  logic             illegal_q, fault_q;
  logic [CNT_W-1:0] retired_q;
  logic             load, timeout;

  mc_ctrl_decode u_decode (
    .opcode_i  (inst[31:26]),
    .funct_i   (inst[5:0]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  assign load    = (state_q == S_FETCH) && inst_ack;
  assign timeout = (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (inst_ack)     state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: state_d = ctrl_q.is_mem ? S_MEM : S_COMMIT;
      S_MEM: begin
        if (mem_ack)      state_d = S_COMMIT;
        else if (timeout) state_d = S_FAULT;
      end
      S_COMMIT: state_d = run ? S_FETCH : S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are derived from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
      z_q        <= 1'b0;
      inst_req_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      cpu_en_q   <= 1'b0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      fault_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
      inst_req_q <= (state_d == S_FETCH);
      mem_req_q  <= (state_d == S_MEM);
      mem_wr_q   <= (state_d == S_MEM) && ctrl_q.is_store;
      cpu_en_q   <= (state_d == S_COMMIT);
      regwrite_q <= (state_d == S_COMMIT) && ctrl_q.regwrite;
      if (state_d == S_FAULT) fault_q <= 1'b1;
      if (load) begin
        ir_q      <= inst[25:0];
        ctrl_q    <= dec_ctrl;
        illegal_q <= illegal_q | dec_illegal;
      end
      if (state_q == S_DECODE) z_q <= zero;
      if (state_q == S_COMMIT) retired_q <= retired_q + RET_ONE;
    end
  end

  assign inst_req    = inst_req_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign cpu_en      = cpu_en_q;
  assign RegWrite    = regwrite_q;
  assign inst_field  = ir_q;
  assign RegDst      = ctrl_q.regdst;
  assign ALUSrc_B    = ctrl_q.alusrc;
  assign Jal         = ctrl_q.jal;
  assign DatatoReg   = ctrl_q.dtr;
  assign ALU_Control = ctrl_q.alu;
  assign Branch      = br_resolve(ctrl_q.brc, z_q);
  assign illegal     = illegal_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

endmodule

// File: doc/mc_ctrl_unit.md
Name: mc_ctrl_unit

Overview:
- Multi-cycle sequencer for the single-cycle MIPS datapath.
- Fetches each instruction over a req/ack port, latches it into an internal IR and decodes it into the datapath control word.
- Holds that control word stable while the ALU settles and any data-memory access completes.
- Pulses `cpu_en` for exactly one cycle per instruction, so PC update and register write happen once per instruction.

Parameters:
ACK_TIMEOUT, 255, max cycles to wait for `inst_ack` or `mem_ack` before entering FAULT (8-bit counter).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all state changes on its rising edge
rst  in  1  synchronous, active-high reset
run  in  1  1 = execute continuously; 0 = stop at the next instruction boundary
inst  in  32  instruction word from instruction memory, valid when `inst_ack`=1
inst_req  out  1  instruction fetch request
inst_ack  in  1  instruction fetch complete
mem_req  out  1  data-memory access request
mem_wr  out  1  1 = store, 0 = load; valid while `mem_req`=1
mem_ack  in  1  data access complete
zero  in  1  ALU zero flag from the datapath
inst_field  out  26  IR[25:0] to the datapath
RegDst  out  1  1 = rd, 0 = rt/31
ALUSrc_B  out  1  1 = sign-extended immediate, 0 = rt
Jal  out  1  1 = write address 31
RegWrite  out  1  register write enable; asserted only in COMMIT
DatatoReg  out  2  00 ALU, 01 mem, 10 lui, 11 pc+4
Branch  out  2  00 pc+4, 01 branch target, 10 jump, 11 jr (rs)
ALU_Control  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt
cpu_en  out  1  one-cycle commit strobe
illegal  out  1  sticky: an unknown opcode/funct was seen
fault  out  1  sticky: ack timeout occurred
retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset: clock `clk`; `rst` is synchronous, active-high.
  - State = IDLE; IR = 0.
  - All outputs 0, including `retired`, `illegal` and `fault`.
- `rst` asserted in any state aborts the operation in progress; requests drop on the next cycle.
- States: IDLE, FETCH, DECODE, MEM, COMMIT, FAULT.
- IDLE: `run`=1 -> FETCH.
- FETCH:
  - `inst_req`=1 every cycle in this state.
  - `inst_ack`=1 (may arrive in the first FETCH cycle) -> IR <= `inst`, wait counter cleared, go to DECODE.
  - Wait counter reaches ACK_TIMEOUT -> FAULT.
- DECODE, one cycle:
  - Control outputs are registered decodes of IR, valid from this cycle until COMMIT ends.
  - `zero` is sampled into z_q at the end of the cycle.
  - lw/sw -> MEM; all other instructions -> COMMIT.
- MEM:
  - `mem_req`=1; `mem_wr`=1 for sw.
  - Control outputs stay stable (`Data_in` must be valid for lw).
  - `mem_ack` -> COMMIT; timeout -> FAULT.
- COMMIT, one cycle:
  - `cpu_en`=1.
  - `RegWrite`=1 for instructions that write a register.
  - `retired` += 1, wrapping at 2^CNT_W.
  - Next state: FETCH if `run`=1, else IDLE.
- FAULT: all requests, `cpu_en` and `RegWrite` = 0; `fault`=1; exit only on `rst`.
- Branch resolution:
  - beq: `Branch`=01 if z_q=1, else 00.
  - bne: `Branch`=01 if z_q=0, else 00.
  - j/jal: `Branch`=10; jr: `Branch`=11.
  - jal additionally: `Jal`=1, `DatatoReg`=11, `RegWrite`=1.
- Supported instructions:
  - R-type: add, sub, and, or, xor, nor, slt, srl, jr.
  - I-type: addi, andi, ori, xori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Unknown opcode/funct: set `illegal`, then commit as a NOP (`RegWrite`=0, `Branch`=00) so the PC advances.
- Latency, zero-wait acks: 3 cycles per instruction (FETCH, DECODE, COMMIT); lw/sw 4 cycles.
- `run` deasserted mid-instruction: the current instruction completes through COMMIT, then IDLE.
- `inst_ack`/`mem_ack` arriving outside their wait state: ignored.

Decomposition:
- Shared header (existing `define.vh` style) holds:
  - opcode and funct constants;
  - ALU_Control codes;
  - DatatoReg and Branch encodings;
  - state encodings.
- One sub-module, mc_ctrl_decode: purely combinational IR -> {RegDst, ALUSrc_B, Jal, RegWrite_i, DatatoReg, branch class, ALU_Control, is_mem, is_store, illegal_i}.
- The FSM, timeout counter, z_q and `retired` live in mc_ctrl_unit.

Test Plan:
- Reset, then `run`=1, fetch add $3,$1,$2 (0x00221820) with immediate ack -> `cpu_en` high exactly in cycle 3; `RegDst`=1, `ALU_Control`=010, `DatatoReg`=00, `RegWrite`=1; `retired`=1.
- lw $4,8($0) (0x8C040008), `mem_ack` delayed 5 cycles -> `mem_req`=1 for 5 cycles, `mem_wr`=0, `ALUSrc_B`=1, `DatatoReg`=01; COMMIT in cycle 8.
- beq with `zero`=1, then beq with `zero`=0 -> `Branch`=01 in the first COMMIT, 00 in the second; bne gives the inverse.
- jal 0x0100000 (0x0C100000) -> `Branch`=10, `Jal`=1, `DatatoReg`=11, `RegWrite`=1 in COMMIT.
- Opcode 0x3F -> `illegal`=1 and sticky, `RegWrite`=0, `cpu_en` pulses once, next FETCH follows.
- `inst_ack` held low for 255 cycles -> FAULT, `fault`=1, `inst_req`=0; assert `rst` -> IDLE with all outputs 0.
